// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I controller: FSM states,
// ALU operations, opcode values and datapath select codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R, S_EXEC_I,
    S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2, S_LUI, S_AUIPC, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3, ALU_XOR = 4'd4,
    ALU_SLL  = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_SLT = 4'd8, ALU_SLTU = 4'd9
  } alu_op_t;

  // Which flavour of ALU operation the current state needs.
  typedef enum logic [1:0] {OPC_ADD, OPC_SUB, OPC_R, OPC_I} opclass_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                         IMM_J = 3'b011, IMM_U = 3'b100;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01,
                         RES_ALURESULT = 2'b10, RES_IMMEXT = 2'b11;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_A = 2'b10;
  localparam logic [1:0] SRCB_WD = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_STORE:          return IMM_S;
      OP_BRANCH:         return IMM_B;
      OP_JAL:            return IMM_J;
      OP_LUI, OP_AUIPC:  return IMM_U;
      default:           return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller (master) and the datapath (slave).
interface multicycle_controller_if;
  import riscv_ctrl_pkg::*;

  logic [31:0] instr;
  logic        Zero, cout, overflow, sign;
  logic        mem_ready;
  logic [2:0]  ImmSrc;
  alu_op_t     ALUControl;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB;
  logic        AdrSrc, IRWrite, RegWrite, PCWrite, MemWrite;
  logic        illegal_instr, instr_retire;

  modport master (
    input  instr, Zero, cout, overflow, sign, mem_ready,
    output ImmSrc, ALUControl, ResultSrc, ALUSrcA, ALUSrcB, AdrSrc,
           IRWrite, RegWrite, PCWrite, MemWrite, illegal_instr, instr_retire
  );

  modport slave (
    output instr, Zero, cout, overflow, sign, mem_ready,
    input  ImmSrc, ALUControl, ResultSrc, ALUSrcA, ALUSrcB, AdrSrc,
           IRWrite, RegWrite, PCWrite, MemWrite, illegal_instr, instr_retire
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU operation select from operation class, funct3 and funct7 bit 5.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  opclass_t   opclass,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  output alu_op_t    alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (opclass)
      OPC_SUB: alu_control = ALU_SUB;
      OPC_R, OPC_I: begin
        case (funct3)
          // Immediate forms have no subtract; funct7b5 is part of the immediate there.
          3'b000: alu_control = (opclass == OPC_R && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001: alu_control = ALU_SLL;
          3'b010: alu_control = ALU_SLT;
          3'b011: alu_control = ALU_SLTU;
          3'b100: alu_control = ALU_XOR;
          3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110: alu_control = ALU_OR;
          3'b111: alu_control = ALU_AND;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore sequencer for the multicycle RV32I datapath. Define MEM_WAIT_EN to make
// FETCH/MEMREAD/MEMWRITE stall on mem_ready; otherwise memory is single-cycle.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  state_t     state_reg, state_next;
  opclass_t   opclass;
  alu_op_t    dec_alu;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5, mem_ok, taken;

  assign op       = bus.instr[6:0];
  assign funct3   = bus.instr[14:12];
  assign funct7b5 = bus.instr[30];

`ifdef MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    opclass = OPC_ADD;
    case (state_reg)
      S_EXEC_R: opclass = OPC_R;
      S_EXEC_I: opclass = OPC_I;
      S_BRANCH: opclass = OPC_SUB;
      default:  opclass = OPC_ADD;
    endcase
  end

  alu_decoder u_alu_decoder (
    .opclass     (opclass),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (dec_alu)
  );

  assign bus.ALUControl = reset ? dec_alu : ALU_ADD;

  // Branch condition from the flags of rs1 - rs2.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = !bus.Zero;
      3'b100:  taken = bus.sign ^ bus.overflow;
      3'b101:  taken = !(bus.sign ^ bus.overflow);
      3'b110:  taken = !bus.cout;
      3'b111:  taken = bus.cout;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next        = state_reg;
    bus.ImmSrc        = imm_src_of(op);
    bus.ResultSrc     = RES_ALUOUT;
    bus.ALUSrcA       = SRCA_PC;
    bus.ALUSrcB       = SRCB_WD;
    bus.AdrSrc        = 1'b0;
    bus.IRWrite       = 1'b0;
    bus.RegWrite      = 1'b0;
    bus.PCWrite       = 1'b0;
    bus.MemWrite      = 1'b0;
    bus.illegal_instr = 1'b0;
    bus.instr_retire  = 1'b0;

    case (state_reg)
      S_FETCH: begin
        bus.IRWrite   = mem_ok;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        bus.PCWrite   = mem_ok;
        if (mem_ok) state_next = S_DECODE;
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_R:              state_next = S_EXEC_R;
          OP_I:              state_next = S_EXEC_I;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR1;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          OP_BRANCH:         state_next = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
          default:           state_next = S_TRAP;
        endcase
        // Without trapping, an illegal instruction retires as a NOP.
        if (state_next == S_TRAP && !ILLEGAL_TRAP) begin
          state_next       = S_FETCH;
          bus.instr_retire = 1'b1;
        end
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_A;
        bus.ALUSrcB = SRCB_IMM;
        state_next  = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.AdrSrc = 1'b1;
        if (mem_ok) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc    = RES_DATA;
        bus.RegWrite     = 1'b1;
        bus.instr_retire = 1'b1;
        state_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.AdrSrc       = 1'b1;
        bus.MemWrite     = mem_ok;
        bus.instr_retire = mem_ok;
        if (mem_ok) state_next = S_FETCH;
      end
      S_EXEC_R: begin
        bus.ALUSrcA = SRCA_A;
        state_next  = S_ALUWB;
      end
      S_EXEC_I, S_JALR1: begin
        bus.ALUSrcA = SRCA_A;
        bus.ALUSrcB = SRCB_IMM;
        state_next  = (state_reg == S_JALR1) ? S_JALR2 : S_ALUWB;
      end
      S_ALUWB: begin
        bus.RegWrite     = 1'b1;
        bus.instr_retire = 1'b1;
        state_next       = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA      = SRCA_A;
        bus.PCWrite      = taken;
        bus.instr_retire = 1'b1;
        state_next       = S_FETCH;
      end
      S_JAL, S_JALR2: begin
        // PC <= target from ALUOut while the ALU forms OldPC+4 for rd.
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        bus.PCWrite = 1'b1;
        state_next  = S_ALUWB;
      end
      S_LUI: begin
        bus.ResultSrc    = RES_IMMEXT;
        bus.RegWrite     = 1'b1;
        bus.instr_retire = 1'b1;
        state_next       = S_FETCH;
      end
      S_AUIPC: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        state_next  = S_ALUWB;
      end
      S_TRAP: begin
        bus.illegal_instr = 1'b1;
        state_next        = S_TRAP;
      end
      default: state_next = S_FETCH;
    endcase

    if (!reset) begin
      bus.ImmSrc        = '0;
      bus.ResultSrc     = '0;
      bus.ALUSrcA       = '0;
      bus.ALUSrcB       = '0;
      bus.AdrSrc        = 1'b0;
      bus.IRWrite       = 1'b0;
      bus.RegWrite      = 1'b0;
      bus.PCWrite       = 1'b0;
      bus.MemWrite      = 1'b0;
      bus.illegal_instr = 1'b0;
      bus.instr_retire  = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expected control vectors
// are queued when an instruction is presented and compared as the FSM steps.
module tb_multicycle_controller;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   errors = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs;

  multicycle_controller_if bus();

  multicycle_controller #(.ILLEGAL_TRAP(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.ImmSrc, 4'(bus.ALUControl), bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
                bus.AdrSrc, bus.IRWrite, bus.RegWrite, bus.PCWrite, bus.MemWrite,
                bus.illegal_instr, bus.instr_retire};

  task automatic check(input string tag, input logic [19:0] got, input logic [19:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] mk(input logic [2:0] imm, input logic [3:0] alu,
      input logic [1:0] res, input logic [1:0] a, input logic [1:0] b, input logic adr,
      input logic irw, input logic rw, input logic pcw, input logic mw,
      input logic ill, input logic ret);
    return {imm, alu, res, a, b, adr, irw, rw, pcw, mw, ill, ret};
  endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      7'h23:        return 3'b001;
      7'h63:        return 3'b010;
      7'h6F:        return 3'b011;
      7'h37, 7'h17: return 3'b100;
      default:      return 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic f7, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7) ? 4'd1 : 4'd0;
      3'b001:  return 4'd5;
      3'b010:  return 4'd8;
      3'b011:  return 4'd9;
      3'b100:  return 4'd4;
      3'b101:  return f7 ? 4'd7 : 4'd6;
      3'b110:  return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // flg = {Zero, cout, overflow, sign}
  function automatic logic exp_taken(input logic [2:0] f3, input logic [3:0] flg);
    case (f3)
      3'b000:  return flg[3];
      3'b001:  return !flg[3];
      3'b100:  return flg[0] ^ flg[1];
      3'b101:  return !(flg[0] ^ flg[1]);
      3'b110:  return !flg[2];
      3'b111:  return flg[2];
      default: return 1'b0;
    endcase
  endfunction

  task automatic push_instr(input logic [31:0] ins, input logic [3:0] flg);
    logic [2:0] imm;
    logic [19:0] aluwb;
    imm   = exp_imm(ins[6:0]);
    aluwb = mk(imm, 4'd0, 2'b00, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0, 1);
    exp_q.push_back(mk(imm, 4'd0, 2'b10, 2'd0, 2'd2, 0, 1, 0, 1, 0, 0, 0));
    exp_q.push_back(mk(imm, 4'd0, 2'b00, 2'd1, 2'd1, 0, 0, 0, 0, 0, 0, 0));
    case (ins[6:0])
      7'h03: begin
        exp_q.push_back(mk(imm, 4'd0, 2'b00, 2'd2, 2'd1, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(imm, 4'd0, 2'b00, 2'd0, 2'd0, 1, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(imm, 4'd0, 2'b01, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0, 1));
      end
      7'h23: begin
        exp_q.push_back(mk(imm, 4'd0, 2'b00, 2'd2, 2'd1, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(imm, 4'd0, 2'b00, 2'd0, 2'd0, 1, 0, 0, 0, 1, 0, 1));
      end
      7'h33: begin
        exp_q.push_back(mk(imm, exp_alu(ins[14:12], ins[30], 1), 2'b00, 2'd2, 2'd0, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(aluwb);
      end
      7'h13: begin
        exp_q.push_back(mk(imm, exp_alu(ins[14:12], ins[30], 0), 2'b00, 2'd2, 2'd1, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(aluwb);
      end
      7'h6F: begin
        exp_q.push_back(mk(imm, 4'd0, 2'b00, 2'd1, 2'd2, 0, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(aluwb);
      end
      7'h67: begin
        exp_q.push_back(mk(imm, 4'd0, 2'b00, 2'd2, 2'd1, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(mk(imm, 4'd0, 2'b00, 2'd1, 2'd2, 0, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(aluwb);
      end
      7'h37: exp_q.push_back(mk(imm, 4'd0, 2'b11, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0, 1));
      7'h17: begin
        exp_q.push_back(mk(imm, 4'd0, 2'b00, 2'd1, 2'd1, 0, 0, 0, 0, 0, 0, 0));
        exp_q.push_back(aluwb);
      end
      default: begin
        if (ins[6:0] == 7'h63 && ins[14:13] != 2'b01)
          exp_q.push_back(mk(imm, 4'd1, 2'b00, 2'd2, 2'd0, 0, 0, 0,
                             exp_taken(ins[14:12], flg), 0, 0, 1));
        else
          for (int i = 0; i < 20; i++)
            exp_q.push_back(mk(imm, 4'd0, 2'b00, 2'd0, 2'd0, 0, 0, 0, 0, 0, 1, 0));
      end
    endcase
  endtask

  task automatic drain(input string tag);
    int n = 0;
    logic [19:0] exp;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      check($sformatf("%s[%0d]", tag, n), obs, exp);
      n++;
      @(posedge clk);
      #1;
    end
    $display("%s: %0d cycles checked", tag, n);
  endtask

  task automatic run(input string tag, input logic [31:0] ins, input logic [3:0] flg);
    bus.instr = ins;
    {bus.Zero, bus.cout, bus.overflow, bus.sign} = flg;
    push_instr(ins, flg);
    drain(tag);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check(tag, obs, 20'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    string       tag;
    logic [31:0] ins;
    logic [3:0]  flg;
  } stim_t;

  stim_t prog[] = '{
    '{"addi",    32'h00500093, 4'b0000}, '{"lw",      32'h0000A103, 4'b0000},
    '{"sw",      32'h0020A023, 4'b0000}, '{"add",     32'h002081B3, 4'b0000},
    '{"sub",     32'h402081B3, 4'b0000}, '{"and",     32'h0020F1B3, 4'b0000},
    '{"srai",    32'h4010D093, 4'b0000}, '{"srli",    32'h0010D093, 4'b0000},
    '{"slti",    32'h0050A093, 4'b0000}, '{"beq_t",   32'h00208463, 4'b1000},
    '{"beq_nt",  32'h00208463, 4'b0000}, '{"bne_t",   32'h00209463, 4'b0000},
    '{"blt_t",   32'h0020C463, 4'b0001}, '{"bge_nt",  32'h0020D463, 4'b0001},
    '{"bltu_t",  32'h0020E463, 4'b0000}, '{"bgeu_t",  32'h0020F463, 4'b0100},
    '{"jal",     32'h008000EF, 4'b0000}, '{"jalr",    32'h000080E7, 4'b0000},
    '{"lui",     32'h123450B7, 4'b0000}, '{"auipc",   32'h12345097, 4'b0000}
  };

  initial begin
    bus.instr = 32'h0;
    bus.mem_ready = 1'b1;
    {bus.Zero, bus.cout, bus.overflow, bus.sign} = 4'b0;
    do_reset("reset_init");

    foreach (prog[i]) run(prog[i].tag, prog[i].ins, prog[i].flg);

    // Reset while MEMWRITE is active: outputs drop at once, then a clean FETCH.
    bus.instr = 32'h0020A023;
    exp_q.push_back(mk(3'b001, 4'd0, 2'b10, 2'd0, 2'd2, 0, 1, 0, 1, 0, 0, 0));
    exp_q.push_back(mk(3'b001, 4'd0, 2'b00, 2'd1, 2'd1, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mk(3'b001, 4'd0, 2'b00, 2'd2, 2'd1, 0, 0, 0, 0, 0, 0, 0));
    drain("sw_pre_reset");
    check("memwrite_active", obs, mk(3'b001, 4'd0, 2'b00, 2'd0, 2'd0, 1, 0, 0, 0, 1, 0, 1));
    do_reset("reset_in_memwrite");
    run("sw_after_reset", 32'h0020A023, 4'b0000);

    run("trap_7f", 32'h0000007F, 4'b0000);
    do_reset("reset_from_trap");
    run("trap_branch_f3_010", 32'h0020A463, 4'b0000);
    do_reset("reset_from_trap2");

`ifdef MEM_WAIT_EN
    bus.instr = 32'h00500093;
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      exp_q.push_back(mk(3'b000, 4'd0, 2'b10, 2'd0, 2'd2, 0, 0, 0, 0, 0, 0, 0));
    drain("fetch_stall");
    bus.mem_ready = 1'b1;
`endif
    run("addi_final", 32'h00500093, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
